// File: rtl/fb_redirect_if.sv
// fb_redirect_if
// Bundles the EX-stage resolve inputs and the fetch redirect / trap outputs of
// fb_redirect_ctrl.
//   master : pipeline side; drives EX operands, stall_in and exc_ack.
//   slave  : redirect controller; drives redir_*, flush, misalign_* and redir_cnt.
// Signals:
//   ex_valid, ex_opcode[4:0], ex_pc[31:0], ex_imm[31:0], ex_rs1[31:0], ex_br_taken
//   stall_in, exc_ack
//   redir_valid, redir_pc[31:0], flush, misalign_exc, misalign_addr[31:0],
//   redir_cnt[15:0]
interface fb_redirect_if;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        ex_br_taken;
    logic        stall_in;
    logic        exc_ack;

    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        flush;
    logic        misalign_exc;
    logic [31:0] misalign_addr;
    logic [15:0] redir_cnt;

    modport master (
        output ex_valid, ex_opcode, ex_pc, ex_imm, ex_rs1, ex_br_taken, stall_in, exc_ack,
        input  redir_valid, redir_pc, flush, misalign_exc, misalign_addr, redir_cnt
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_pc, ex_imm, ex_rs1, ex_br_taken, stall_in, exc_ack,
        output redir_valid, redir_pc, flush, misalign_exc, misalign_addr, redir_cnt
    );
endinterface

// File: rtl/fb_redirect_ctrl.sv
// fb_redirect_ctrl
// Resolves control transfers sitting in EX (taken branch, JAL, JALR), issues a
// registered one-cycle redirect to fetch, then holds flush for FLUSH_CYCLES
// cycles to squash IF/ID. A target with target[1:0] != 0 raises a
// misaligned-target exception that stays pending until exc_ack.
// Ports:
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-high reset
//   bus (slave)  EX operands, stall_in, exc_ack in; redir_valid, redir_pc,
//                flush, misalign_exc, misalign_addr, redir_cnt out
// Parameters:
//   FLUSH_CYCLES  cycles flush stays high after a redirect (1..7)
//   RESET_PC      reset value of redir_pc
// All outputs come straight from flops.
module fb_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fb_redirect_if.slave bus
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : gen_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..7");
    end

    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpJal    = 5'b11011;

    localparam logic [2:0] FcntInit = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StExc
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        flush_q, flush_d;
    logic        exc_q, exc_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic [15:0] cnt_q, cnt_d;

    logic        xfer;
    logic [31:0] target;
    logic        take;

    // Target computation. B/J immediates are halfword offsets, hence the
    // shift; JALR clears bit 0 of the byte-addressed sum.
    always_comb begin
        xfer   = 1'b0;
        target = 32'h0;
        case (bus.ex_opcode)
            OpBranch: begin
                xfer   = bus.ex_br_taken;
                target = bus.ex_pc + {bus.ex_imm[30:0], 1'b0};
            end
            OpJal: begin
                xfer   = 1'b1;
                target = bus.ex_pc + {bus.ex_imm[30:0], 1'b0};
            end
            OpJalr: begin
                xfer   = 1'b1;
                target = (bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE;
            end
            default: begin
                xfer   = 1'b0;
                target = 32'h0;
            end
        endcase
    end

    // Requests are only honoured in IDLE; in FLUSH/EXC the EX slot holds a
    // squashed instruction.
    assign take = (state_q == StIdle) && bus.ex_valid && !bus.stall_in && xfer;

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = flush_q;
        exc_d         = exc_q;
        exc_addr_d    = exc_addr_q;
        cnt_d         = cnt_q;

        // A stall freezes everything, including a pending redir_valid pulse.
        if (!bus.stall_in) begin
            unique case (state_q)
                StIdle: begin
                    redir_valid_d = 1'b0;
                    flush_d       = 1'b0;
                    if (take) begin
                        if (target[1:0] == 2'b00) begin
                            redir_valid_d = 1'b1;
                            redir_pc_d    = target;
                            flush_d       = 1'b1;
                            fcnt_d        = FcntInit;
                            cnt_d         = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                            state_d       = (FLUSH_CYCLES == 1) ? StIdle : StFlush;
                        end else begin
                            exc_d      = 1'b1;
                            exc_addr_d = target;
                            flush_d    = 1'b1;
                            state_d    = StExc;
                        end
                    end
                end
                StFlush: begin
                    redir_valid_d = 1'b0;
                    flush_d       = 1'b1;
                    fcnt_d        = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) begin
                        flush_d = 1'b0;
                        state_d = StIdle;
                    end
                end
                StExc: begin
                    if (bus.exc_ack) begin
                        exc_d   = 1'b0;
                        flush_d = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            fcnt_q        <= 3'd0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= RESET_PC;
            flush_q       <= 1'b0;
            exc_q         <= 1'b0;
            exc_addr_q    <= 32'h0;
            cnt_q         <= 16'h0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            exc_q         <= exc_d;
            exc_addr_q    <= exc_addr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.redir_valid   = redir_valid_q;
    assign bus.redir_pc      = redir_pc_q;
    assign bus.flush         = flush_q;
    assign bus.misalign_exc  = exc_q;
    assign bus.misalign_addr = exc_addr_q;
    assign bus.redir_cnt     = cnt_q;

endmodule

// File: tb/tb_fb_redirect_ctrl.sv
module tb_fb_redirect_ctrl;

    localparam int          FC   = 2;
    localparam logic [31:0] RPC  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_redirect_if bus ();
    fb_redirect_if sat_bus ();

    fb_redirect_ctrl #(.FLUSH_CYCLES(FC), .RESET_PC(RPC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-cycle flush variant: one redirect per cycle, used for saturation.
    fb_redirect_ctrl #(.FLUSH_CYCLES(1), .RESET_PC(32'h0)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts output cycles since a redirect (0 = not in a flush window).
    logic        m_valid, m_flush, m_exc;
    logic [31:0] m_pc, m_addr;
    int          m_cnt, m_age;
    bit          m_in_exc;

    function automatic bit want_redirect(input logic [4:0] op, input logic br,
                                         input logic [31:0] pc, input logic [31:0] imm,
                                         input logic [31:0] rs1, output logic [31:0] tgt);
        tgt = 32'h0;
        if (op == 5'b11000 && br) begin
            tgt = pc + (imm << 1);
            return 1'b1;
        end
        if (op == 5'b11011) begin
            tgt = pc + (imm << 1);
            return 1'b1;
        end
        if (op == 5'b11001) begin
            tgt = (rs1 + imm) & ~32'h1;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [31:0] tgt;
        if (rst) begin
            m_valid = 0; m_flush = 0; m_exc = 0;
            m_pc = RPC; m_addr = 0; m_cnt = 0; m_age = 0; m_in_exc = 0;
        end else if (!bus.stall_in) begin
            if (m_in_exc) begin
                if (bus.exc_ack) begin
                    m_in_exc = 0; m_exc = 0; m_flush = 0;
                end
            end else if (m_age >= 1 && m_age < FC) begin
                m_age++;
                m_valid = 0;
                m_flush = 1;
            end else begin
                m_age = 0; m_valid = 0; m_flush = 0;
                if (bus.ex_valid && want_redirect(bus.ex_opcode, bus.ex_br_taken, bus.ex_pc,
                                                  bus.ex_imm, bus.ex_rs1, tgt)) begin
                    if (tgt % 4 == 0) begin
                        m_valid = 1; m_pc = tgt; m_flush = 1; m_age = 1;
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    end else begin
                        m_exc = 1; m_addr = tgt; m_flush = 1; m_in_exc = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("redir_valid", 32'(bus.redir_valid), 32'(m_valid));
        chk("redir_pc", bus.redir_pc, m_pc);
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("misalign_exc", 32'(bus.misalign_exc), 32'(m_exc));
        chk("misalign_addr", bus.misalign_addr, m_addr);
        chk("redir_cnt", 32'(bus.redir_cnt), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic br);
        bus.ex_valid = 1; bus.ex_opcode = op; bus.ex_pc = pc;
        bus.ex_imm = imm; bus.ex_rs1 = rs1; bus.ex_br_taken = br;
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.ex_opcode = 5'b00100; bus.ex_br_taken = 0;
    endtask

    initial begin
        bus.ex_valid = 0; bus.ex_opcode = 0; bus.ex_pc = 0; bus.ex_imm = 0;
        bus.ex_rs1 = 0; bus.ex_br_taken = 0; bus.stall_in = 0; bus.exc_ack = 0;
        sat_bus.ex_valid = 0; sat_bus.ex_opcode = 0; sat_bus.ex_pc = 0; sat_bus.ex_imm = 0;
        sat_bus.ex_rs1 = 0; sat_bus.ex_br_taken = 0; sat_bus.stall_in = 0;
        sat_bus.exc_ack = 0;

        cyc(2);
        chk("rst_redir_pc", bus.redir_pc, RPC);
        chk("rst_cnt", 32'(bus.redir_cnt), 32'h0);
        rst = 0;
        cyc(1);

        // Taken branch: 0x100 + 8*2 = 0x110
        drive(5'b11000, 32'h100, 32'h8, 32'h0, 1'b1);
        cyc(1);
        chk("br_valid", 32'(bus.redir_valid), 32'h1);
        chk("br_pc", bus.redir_pc, 32'h110);
        chk("br_flush1", 32'(bus.flush), 32'h1);
        chk("br_cnt", 32'(bus.redir_cnt), 32'h1);
        idle();
        cyc(1);
        chk("br_pulse_drop", 32'(bus.redir_valid), 32'h0);
        chk("br_flush2", 32'(bus.flush), 32'h1);
        cyc(1);
        chk("br_flush_end", 32'(bus.flush), 32'h0);

        // Not-taken branch: nothing happens
        drive(5'b11000, 32'h100, 32'h8, 32'h0, 1'b0);
        cyc(1);
        chk("nt_valid", 32'(bus.redir_valid), 32'h0);
        chk("nt_flush", 32'(bus.flush), 32'h0);
        idle();
        cyc(1);

        // JAL backward, held valid across the flush window
        drive(5'b11011, 32'h200, 32'hFFFF_FFFE, 32'h0, 1'b0);
        cyc(1);
        chk("jal_pc", bus.redir_pc, 32'h1FC);
        cyc(1);
        chk("jal_ignored", 32'(bus.redir_valid), 32'h0);
        idle();
        cyc(1);
        chk("jal_cnt", 32'(bus.redir_cnt), 32'h2);

        // JALR, bit 0 cleared
        drive(5'b11001, 32'h0, 32'h3, 32'h1001, 1'b0);
        cyc(1);
        chk("jalr_pc", bus.redir_pc, 32'h1004);
        idle();
        cyc(2);
        // JALR wrap-around
        drive(5'b11001, 32'h0, 32'h8, 32'hFFFF_FFFC, 1'b0);
        cyc(1);
        chk("jalr_wrap_pc", bus.redir_pc, 32'h4);
        chk("jalr_cnt", 32'(bus.redir_cnt), 32'h4);
        idle();
        cyc(2);

        // Misaligned JALR target 0x1002; a JAL sits in EX during the exception
        drive(5'b11001, 32'h0, 32'h2, 32'h1000, 1'b0);
        cyc(1);
        chk("mis_exc", 32'(bus.misalign_exc), 32'h1);
        chk("mis_addr", bus.misalign_addr, 32'h1002);
        chk("mis_no_valid", 32'(bus.redir_valid), 32'h0);
        drive(5'b11011, 32'h300, 32'h10, 32'h0, 1'b0);
        cyc(4);
        chk("mis_flush_held", 32'(bus.flush), 32'h1);
        bus.exc_ack = 1;
        cyc(1);
        chk("ack_exc_clr", 32'(bus.misalign_exc), 32'h0);
        chk("ack_flush_clr", 32'(bus.flush), 32'h0);
        chk("ack_cnt", 32'(bus.redir_cnt), 32'h4);
        bus.exc_ack = 0;
        cyc(1);
        chk("post_ack_pc", bus.redir_pc, 32'h320);
        idle();
        cyc(2);

        // Stall holds the pulse: request N, stall N+1..N+3
        drive(5'b11011, 32'h400, 32'h4, 32'h0, 1'b0);
        cyc(1);
        idle();
        bus.stall_in = 1;
        cyc(3);
        chk("stall_valid_held", 32'(bus.redir_valid), 32'h1);
        chk("stall_pc", bus.redir_pc, 32'h408);
        bus.stall_in = 0;
        cyc(1);
        chk("stall_valid_drop", 32'(bus.redir_valid), 32'h0);
        chk("stall_flush", 32'(bus.flush), 32'h1);
        cyc(1);
        chk("stall_flush_end", 32'(bus.flush), 32'h0);

        // Asynchronous reset mid-FLUSH
        drive(5'b11011, 32'h500, 32'h4, 32'h0, 1'b0);
        cyc(1);
        idle();
        cyc(1);
        rst = 1;
        #1;
        chk("arst_valid", 32'(bus.redir_valid), 32'h0);
        chk("arst_pc", bus.redir_pc, RPC);
        chk("arst_flush", 32'(bus.flush), 32'h0);
        chk("arst_cnt", 32'(bus.redir_cnt), 32'h0);
        cyc(1);
        rst = 0;
        cyc(1);

        // Saturation on the single-cycle-flush instance
        sat_bus.ex_valid = 1; sat_bus.ex_opcode = 5'b11011;
        sat_bus.ex_pc = 32'h0; sat_bus.ex_imm = 32'h4;
        cyc(65534);
        chk("sat_cnt_fffe", 32'(sat_bus.redir_cnt), 32'hFFFE);
        cyc(3);
        chk("sat_cnt_ffff", 32'(sat_bus.redir_cnt), 32'hFFFF);
        chk("sat_pc", sat_bus.redir_pc, 32'h8);
        sat_bus.ex_valid = 0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
